// File: rtl/rfft_ctrl.sv
// Frame sequencer for the 4-bank in-place FFT datapath.
// Runs LOAD, NUM_STAGES butterfly passes, then UNLOAD, and drives every mux, PE and RAM control.
module rfft_ctrl #(
  parameter int ADDR_BIT   = 3,
  parameter int NUM_STAGES = 3,
  parameter int RD_LAT     = 1,
  parameter int PE_LAT     = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic                    in_valid,
  output logic                    in_ready,
  output logic                    out_valid,
  output logic                    busy,
  output logic                    done,
  output logic                    m0,
  output logic                    m11,
  output logic [1:0]              m12,
  output logic [1:0]              m13,
  output logic                    m14,
  output logic                    m21,
  output logic                    m22,
  output logic                    m23,
  output logic                    m24,
  output logic                    bypass_en,
  output logic                    en,
  output logic                    we,
  output logic                    re,
  output logic [4*ADDR_BIT-1:0]   addr_read,
  output logic [4*ADDR_BIT-1:0]   addr_write,
  output logic [ADDR_BIT-1:0]     tw_idx
);

  localparam int DEPTH = 1 << ADDR_BIT;
  localparam int PIPE  = RD_LAT + PE_LAT;
  localparam int CW    = $clog2(DEPTH + PIPE + 1) + 1;
  localparam int SW    = 4;
  localparam int AW    = 4 * ADDR_BIT;

  localparam logic [CW-1:0]       C_DEPTH = CW'(DEPTH);
  localparam logic [CW-1:0]       C_PIPE  = CW'(PIPE);
  localparam logic [CW-1:0]       C_RDLAT = CW'(RD_LAT);
  localparam logic [CW-1:0]       C_CLAST = CW'(DEPTH + PIPE - 1);
  localparam logic [CW-1:0]       C_ULAST = CW'(DEPTH + RD_LAT - 1);
  localparam logic [SW-1:0]       C_SLAST = SW'(NUM_STAGES - 1);
  localparam logic [ADDR_BIT-1:0] C_LMAX  = ADDR_BIT'(DEPTH - 1);

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_COMP, S_UNLOAD, S_FIN} state_t;

  typedef struct packed {
    logic                in_ready;
    logic                out_valid;
    logic                m0;
    logic                m11;
    logic [1:0]          m12;
    logic [1:0]          m13;
    logic                m14;
    logic                m21;
    logic                m22;
    logic                m23;
    logic                m24;
    logic                bypass_en;
    logic                en;
    logic                we;
    logic                re;
    logic [AW-1:0]       ar;
    logic [AW-1:0]       aw;
    logic [ADDR_BIT-1:0] tw;
  } ctl_t;

  function automatic ctl_t ctl_load();
    ctl_t k;
    k           = '0;
    k.in_ready  = 1'b1;
    k.en        = 1'b1;
    k.bypass_en = 1'b1;
    return k;
  endfunction

  // Control word for butterfly cycle c of stage s; writes trail reads by PIPE cycles.
  function automatic ctl_t ctl_comp(input logic [CW-1:0] c, input logic [SW-1:0] s);
    ctl_t                k;
    logic [ADDR_BIT-1:0] wa;
    k    = '0;
    k.m0 = 1'b1;
    k.en = 1'b1;
    k.re = (c < C_DEPTH);
    if (k.re) begin
      k.ar = {4{c[ADDR_BIT-1:0]}};
      k.tw = c[ADDR_BIT-1:0] << s;
    end
    k.we = (c >= C_PIPE);
    if (k.we) begin
      wa   = ADDR_BIT'(c - C_PIPE);
      k.aw = {4{wa}};
    end
    k.m11 = 1'b0;
    k.m14 = 1'b1;
    if (s == '0) begin
      k.m12 = 2'd2;
      k.m13 = 2'd0;
    end else begin
      k.m12 = 2'd1;
      k.m13 = 2'd1;
    end
    if (s[0]) begin
      k.m21 = 1'b1;
      k.m22 = 1'b1;
    end else begin
      k.m23 = 1'b1;
      k.m24 = 1'b1;
    end
    return k;
  endfunction

  function automatic ctl_t ctl_unload(input logic [CW-1:0] u);
    ctl_t k;
    k           = '0;
    k.re        = 1'b1;
    k.en        = 1'b1;
    k.bypass_en = 1'b1;
    if (u < C_DEPTH) k.ar = {4{u[ADDR_BIT-1:0]}};
    k.out_valid = (u >= C_RDLAT);
    return k;
  endfunction

  state_t              r_state;
  logic [ADDR_BIT-1:0] r_lcnt;
  logic [CW-1:0]       r_cnt;
  logic [SW-1:0]       r_stage;
  ctl_t                r_ctl;
  logic                r_busy;
  logic                r_done;

  logic [CW-1:0]       w_cnt_inc;
  logic [SW-1:0]       w_stage_inc;
  logic                w_load_acc;

  assign w_cnt_inc   = r_cnt + 1'b1;
  assign w_stage_inc = r_stage + 1'b1;
  assign w_load_acc  = (r_state == S_LOAD) && in_valid && r_ctl.in_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_lcnt  <= '0;
      r_cnt   <= '0;
      r_stage <= '0;
      r_ctl   <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_state <= S_LOAD;
            r_busy  <= 1'b1;
            r_lcnt  <= '0;
            r_ctl   <= ctl_load();
          end
        end
        S_LOAD: begin
          if (w_load_acc) begin
            if (r_lcnt == C_LMAX) begin
              r_state <= S_COMP;
              r_cnt   <= '0;
              r_stage <= '0;
              r_ctl   <= ctl_comp('0, '0);
            end else begin
              r_lcnt <= r_lcnt + 1'b1;
            end
          end
        end
        S_COMP: begin
          if (r_cnt == C_CLAST) begin
            r_cnt <= '0;
            if (r_stage == C_SLAST) begin
              r_state <= S_UNLOAD;
              r_ctl   <= ctl_unload('0);
            end else begin
              r_stage <= w_stage_inc;
              r_ctl   <= ctl_comp('0, w_stage_inc);
            end
          end else begin
            r_cnt <= w_cnt_inc;
            r_ctl <= ctl_comp(w_cnt_inc, r_stage);
          end
        end
        S_UNLOAD: begin
          if (r_cnt == C_ULAST) begin
            r_state <= S_FIN;
            r_cnt   <= '0;
            r_ctl   <= '0;
            r_done  <= 1'b1;
          end else begin
            r_cnt <= w_cnt_inc;
            r_ctl <= ctl_unload(w_cnt_inc);
          end
        end
        S_FIN: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Sample writes during LOAD follow in_valid within the cycle; everything else is registered.
  assign we         = r_ctl.we | w_load_acc;
  assign addr_write = w_load_acc ? {4{r_lcnt}} : r_ctl.aw;

  assign in_ready  = r_ctl.in_ready;
  assign out_valid = r_ctl.out_valid;
  assign busy      = r_busy;
  assign done      = r_done;
  assign m0        = r_ctl.m0;
  assign m11       = r_ctl.m11;
  assign m12       = r_ctl.m12;
  assign m13       = r_ctl.m13;
  assign m14       = r_ctl.m14;
  assign m21       = r_ctl.m21;
  assign m22       = r_ctl.m22;
  assign m23       = r_ctl.m23;
  assign m24       = r_ctl.m24;
  assign bypass_en = r_ctl.bypass_en;
  assign en        = r_ctl.en;
  assign re        = r_ctl.re;
  assign addr_read = r_ctl.ar;
  assign tw_idx    = r_ctl.tw;

endmodule

// File: doc/rfft_ctrl.md
Name: rfft_ctrl

Overview:
- Sequencer (initiator) that drives every control input of the 4-bank FFT datapath: m0, m11–m14, m21–m24, en, we, re, bypass_en, packed read/write addresses and twiddle index.
- Runs LOAD → NUM_STAGES in-place butterfly stages → UNLOAD per frame of 4*DEPTH samples.
- Handshakes with the sample source (in_valid/in_ready) and the host (start/busy/done).

Parameters:
ADDR_BIT, 3, bank address width; DEPTH = 2**ADDR_BIT words per bank
NUM_STAGES, 3, butterfly stages per frame (1..8)
RD_LAT, 1, ram_bank read latency in cycles
PE_LAT, 2, pe input-to-output latency in cycles; PIPE = RD_LAT+PE_LAT

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  asynchronous active-high reset
start  in  1  frame request; sampled only in IDLE
in_valid  in  1  source has 4 samples on datapath in0..in3
in_ready  out  1  controller accepts samples this cycle
out_valid  out  1  mem0_o..mem3_o carry result word
busy  out  1  high in every state except IDLE
done  out  1  one-cycle pulse when frame completes
m0, m11, m14, m21, m22, m23, m24, bypass_en  out  1 each  datapath mux/PE controls
m12, m13  out  2 each  mux31 selects (0/1/2 = first/second/third input)
en, we, re  out  1 each  RAM bank controls
addr_read, addr_write  out  4*ADDR_BIT  bank k address in bits [ADDR_BIT*(k+1)-1 : ADDR_BIT*k]
tw_idx  out  ADDR_BIT  twiddle ROM index feeding w_r/w_i

Behaviour:
- Reset (async, any state): state=IDLE; all outputs 0; counters cleared; an in-flight frame is abandoned.
- States: IDLE, LOAD, COMP, UNLOAD, FIN.
- IDLE: start=1 → LOAD next cycle. start is ignored in all other states.
- LOAD: in_ready=1, m0=0, en=1, bypass_en=1. On each in_valid&in_ready cycle, we=1 combinationally and all four addr_write fields = lcnt; then lcnt++. in_valid=0 → we=0, no advance. After DEPTH accepts → COMP, stage s=0, in_ready=0.
- COMP, stage s: m0=1, bypass_en=0, en=1. Cycle counter c runs 0..DEPTH+PIPE-1.
  - re=1 for c<DEPTH; all addr_read fields = c[ADDR_BIT-1:0].
  - we=1 for PIPE ≤ c < DEPTH+PIPE; all addr_write fields = c-PIPE (in-place write).
  - tw_idx = (c << s) mod DEPTH while re=1, else 0.
  - s==0 (cross pairs 0/2, 1/3): m11=0, m12=2, m13=0, m14=1.
  - s≥1 (adjacent pairs 0/1, 2/3): m11=0, m12=1, m13=1, m14=1.
  - Output muxes: s even → m21..m24 = 0,0,1,1; s odd → 1,1,0,0.
  - Selects are held constant for the whole stage, including the drain cycles.
  - Stage end (c=DEPTH+PIPE-1): s++; if s==NUM_STAGES → UNLOAD.
  - Stage length is exactly DEPTH+PIPE cycles. The next stage's first read occurs after the previous stage's last write, so there is no read-after-write hazard.
- UNLOAD: re=1, en=1, bypass_en=1, we=0, m0=0. Counter u runs 0..DEPTH+RD_LAT-1.
  - addr_read = u for u<DEPTH.
  - out_valid=1 for RD_LAT ≤ u < DEPTH+RD_LAT.
  - There is no backpressure.
  - After the last cycle → FIN.
- FIN: done=1 for one cycle, busy=1 → IDLE.
- All control outputs are registered except we/addr_write in LOAD, which follow in_valid within the cycle.
- Counter widths must hold DEPTH+PIPE without overflow. tw_idx shift is truncated to ADDR_BIT bits.

Test Plan:
- Reset mid-COMP (s=1, c=5), asserted asynchronously between edges → busy, we, re, out_valid, in_ready = 0 immediately; next start begins a fresh LOAD with lcnt=0.
- Defaults, start pulse, in_valid held 1 → in_ready high 8 cycles; addr_write fields = 0..7 with we=1. COMP lasts 3×11 = 33 cycles. UNLOAD out_valid high 8 cycles after a 1-cycle gap. done pulses once; busy falls the cycle after done.
- LOAD with in_valid toggling 1,0,1,0 → lcnt advances only on valid cycles; LOAD exits after exactly the 8th accept.
- Stage 0 → m12=2, m13=0, m21..m24 = 0,0,1,1. Stage 1 → m12=1, m13=1, m21..m24 = 1,1,0,0. Stage 1 tw_idx sequence 0,2,4,6,0,2,4,6.
- In each stage, we first rises at c=3 with addr_write=0 and falls after c=10 (addr_write=7). re covers c=0..7 only.
- start asserted during COMP and during FIN → ignored; exactly one frame runs.
